// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline operand forwarding, load-use / HI-LO busy stall
//               detection, multiply/divide occupancy tracking, stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit #(
  parameter int MULT_LATENCY = 4,
  parameter int DIV_LATENCY  = 16
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [4:0]  IFIDRs_IN,
  input  logic [4:0]  IFIDRt_IN,
  input  logic        HiLoUse_IN,
  input  logic [4:0]  IDEXERs_IN,
  input  logic [4:0]  IDEXERt_IN,
  input  logic        IDEXEMemRead_IN,
  input  logic [4:0]  IDEXEWriteReg_IN,
  input  logic        MulDivStart_IN,
  input  logic        IsDiv_IN,
  input  logic        EXEMEMRegWrite_IN,
  input  logic [4:0]  EXEMEMWriteReg_IN,
  input  logic        MEMWBRegWrite_IN,
  input  logic [4:0]  MEMWBWriteReg_IN,
  output logic [1:0]  ForwardRS_OUT,
  output logic [1:0]  ForwardRT_OUT,
  output logic        Stall_OUT,
  output logic        Flush_OUT,
  output logic        MdBusy_OUT,
  output logic [31:0] StallCount_OUT
);

  localparam logic [4:0] c_MULT_LOAD = 5'(MULT_LATENCY - 1);
  localparam logic [4:0] c_DIV_LOAD  = 5'(DIV_LATENCY - 1);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_MD_BUSY = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_md_count;
  logic [4:0]  w_md_count_nxt;
  logic [31:0] r_stall_cnt;
  logic        w_lu;
  logic        w_mh;

  // EXE/MEM wins over MEM/WB; register 0 is hardwired and never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (EXEMEMRegWrite_IN && (EXEMEMWriteReg_IN != 5'd0) && (EXEMEMWriteReg_IN == src))
      sel = 2'b10;
    else if (MEMWBRegWrite_IN && (MEMWBWriteReg_IN != 5'd0) && (MEMWBWriteReg_IN == src))
      sel = 2'b01;
    return sel;
  endfunction

  always_comb begin
    ForwardRS_OUT = fwd_sel(IDEXERs_IN);
    ForwardRT_OUT = fwd_sel(IDEXERt_IN);
  end

  always_comb begin
    w_lu = IDEXEMemRead_IN && (IDEXEWriteReg_IN != 5'd0) &&
           ((IDEXEWriteReg_IN == IFIDRs_IN) || (IDEXEWriteReg_IN == IFIDRt_IN));
    w_mh = (r_state == S_MD_BUSY) && HiLoUse_IN;
  end

  assign Stall_OUT      = w_lu || w_mh;
  assign Flush_OUT      = w_lu || w_mh;
  assign MdBusy_OUT     = (r_state == S_MD_BUSY);
  assign StallCount_OUT = r_stall_cnt;

  // A new start while busy is ignored so the running operation keeps its count.
  always_comb begin
    w_state_nxt    = r_state;
    w_md_count_nxt = r_md_count;
    case (r_state)
      S_IDLE: begin
        if (MulDivStart_IN) begin
          w_state_nxt    = S_MD_BUSY;
          w_md_count_nxt = IsDiv_IN ? c_DIV_LOAD : c_MULT_LOAD;
        end
      end
      S_MD_BUSY: begin
        if (r_md_count != 5'd0)
          w_md_count_nxt = r_md_count - 5'd1;
        else
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_md_count_nxt = 5'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_md_count  <= 5'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_md_count <= w_md_count_nxt;
      if (Stall_OUT && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire
